// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 active-low matrix keypad: plays queued-free key presses as
// press bounce, hold, release bounce and release gap, pulling one row low per column drive.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned BOUNCE_TOGGLE = 3,
  parameter int unsigned HOLD_CYCLES   = 2000000,
  parameter int unsigned GAP_CYCLES    = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       press_valid,
  input  logic [3:0] press_key,
  output logic       press_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MaxBh  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxBhg = (MaxBh > GAP_CYCLES) ? MaxBh : GAP_CYCLES;
  localparam int unsigned MaxLen = (MaxBhg > BOUNCE_TOGGLE) ? MaxBhg : BOUNCE_TOGGLE;
  localparam int unsigned Cw     = $clog2(MaxLen + 1);

  localparam int unsigned BounceLastI = (BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1;

  localparam logic [Cw-1:0] BounceLast = Cw'(BounceLastI);
  localparam logic [Cw-1:0] ToggleLast = Cw'(BOUNCE_TOGGLE - 1);
  localparam logic [Cw-1:0] HoldLast   = Cw'(HOLD_CYCLES - 1);
  localparam logic [Cw-1:0] GapLast    = Cw'(GAP_CYCLES - 1);
  localparam logic [Cw-1:0] CntOne     = Cw'(1);

  typedef enum logic [2:0] {
    StIdle,
    StPressBounce,
    StHold,
    StRelBounce,
    StGap
  } state_e;

  state_e        state_q, state_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic [Cw-1:0] tog_q, tog_d;
  logic          contact_q, contact_d;
  logic [3:0]    key_q, key_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tog_q     <= '0;
      contact_q <= 1'b0;
      key_q     <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      contact_q <= contact_d;
      key_q     <= key_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    contact_d = contact_q;
    key_d     = key_q;
    unique case (state_q)
      StIdle: begin
        if (press_valid) begin
          key_d     = press_key;
          cnt_d     = '0;
          tog_d     = '0;
          contact_d = 1'b1;
          state_d   = (BOUNCE_CYCLES != 0) ? StPressBounce : StHold;
        end
      end
      StPressBounce, StRelBounce: begin
        if (cnt_q == BounceLast) begin
          cnt_d     = '0;
          tog_d     = '0;
          // Each phase starts from its settled contact value.
          contact_d = (state_q == StPressBounce);
          state_d   = (state_q == StPressBounce) ? StHold : StGap;
        end else begin
          cnt_d = cnt_q + CntOne;
          if (tog_q == ToggleLast) begin
            tog_d     = '0;
            contact_d = ~contact_q;
          end else begin
            tog_d = tog_q + CntOne;
          end
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d     = '0;
          tog_d     = '0;
          contact_d = 1'b0;
          state_d   = (BOUNCE_CYCLES != 0) ? StRelBounce : StGap;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        cnt_d     = '0;
        tog_d     = '0;
        contact_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_comb begin
    press_ready = (state_q == StIdle);
    busy        = (state_q != StIdle);
    done        = (state_q == StGap) && (cnt_q == GapLast);
    row         = 4'hF;
    // Same-cycle col->row path; an unknown col bit never enables the pull-down.
    if (contact_q && (col[key_q[1:0]] == 1'b0)) begin
      row[key_q[3:2]] = 1'b0;
    end
  end

endmodule
